// File: rtl/jump_pkg.sv
// Shared types and defaults for the player jump sequencer.
// peak_height gives the apex a jump reaches once rise saturation is applied.
package jump_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RISE,
      ST_HANG,
      ST_FALL,
      ST_COOLDOWN
   } state_t;

   localparam int DEF_TICK_DIV       = 5;
   localparam int DEF_HEIGHT_W       = 8;
   localparam int DEF_STEP           = 4;
   localparam int DEF_RISE_TICKS     = 8;
   localparam int DEF_HANG_TICKS     = 2;
   localparam int DEF_COOLDOWN_TICKS = 4;

   function automatic int peak_height(input int step, input int rise_ticks, input int height_w);
      int max_h;
      int raw;
      max_h = (1 << height_w) - 1;
      raw   = step * rise_ticks;
      return (raw > max_h) ? max_h : raw;
   endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for the raw button level followed by a rising-edge detector.
// The edge output is combinational from registered state, so it is valid one cycle after the second flop.
module btn_sync_edge (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_btn,
   output logic o_rise
);

   logic r_sync1;
   logic r_sync2;
   logic r_prev;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_prev  <= 1'b0;
      end else begin
         r_sync1 <= i_btn;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   assign o_rise = r_sync2 & ~r_prev;

endmodule

// File: rtl/jump_sequencer.sv
// Tick-aligned player jump: prescaler, press capture and a rise/hang/fall/cooldown FSM
// driving an unsigned height offset.
module jump_sequencer
   import jump_pkg::*;
#(
   parameter int TICK_DIV       = DEF_TICK_DIV,
   parameter int HEIGHT_W       = DEF_HEIGHT_W,
   parameter int STEP           = DEF_STEP,
   parameter int RISE_TICKS     = DEF_RISE_TICKS,
   parameter int HANG_TICKS     = DEF_HANG_TICKS,
   parameter int COOLDOWN_TICKS = DEF_COOLDOWN_TICKS
) (
   input  logic                proc_clk,
   input  logic                reset,
   input  logic                jump_btn,
   input  logic                enable,
   output logic                tick,
   output logic                jump_active,
   output logic [HEIGHT_W-1:0] height,
   output logic                can_jump,
   output logic                land_pulse
);

   localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam int PH_W  = 16;
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
   localparam logic [PH_W-1:0]   RISE_LAST = (RISE_TICKS > 0) ? PH_W'(RISE_TICKS - 1) : '0;
   localparam logic [PH_W-1:0]   HANG_LAST = (HANG_TICKS > 0) ? PH_W'(HANG_TICKS - 1) : '0;
   localparam logic [PH_W-1:0]   COOL_LAST = (COOLDOWN_TICKS > 0) ? PH_W'(COOLDOWN_TICKS - 1) : '0;
   localparam logic [HEIGHT_W:0] STEP_X    = (HEIGHT_W + 1)'(STEP);
   localparam state_t            AFTER_RISE = (HANG_TICKS == 0) ? ST_FALL : ST_HANG;

   logic [DIV_W-1:0]  r_div_cnt;
   state_t            r_state;
   state_t            w_state_next;
   logic [PH_W-1:0]   r_phase_cnt;
   logic [PH_W-1:0]   w_phase_next;
   logic [HEIGHT_W-1:0] r_height;
   logic [HEIGHT_W-1:0] w_height_next;
   logic              r_pending;
   logic              w_pending_next;
   logic              r_land_pulse;
   logic              w_land_next;
   logic              w_btn_rise;
   logic              w_tick;
   logic              w_start;
   logic [HEIGHT_W:0] w_sum;
   logic [HEIGHT_W:0] w_diff;

   btn_sync_edge u_btn (
      .i_clk   (proc_clk),
      .i_rst_n (reset),
      .i_btn   (jump_btn),
      .o_rise  (w_btn_rise)
   );

   always_ff @(posedge proc_clk or negedge reset) begin
      if (!reset) begin
         r_div_cnt <= '0;
      end else if (w_tick) begin
         r_div_cnt <= '0;
      end else begin
         r_div_cnt <= r_div_cnt + DIV_W'(1);
      end
   end

   assign w_tick  = (r_div_cnt == DIV_LAST);
   assign w_start = w_tick && r_pending && enable && (r_state == ST_IDLE);

   // Extra top bit catches overflow on rise and borrow on fall.
   assign w_sum  = {1'b0, r_height} + STEP_X;
   assign w_diff = {1'b0, r_height} - STEP_X;

   // Presses outside IDLE are dropped rather than queued.
   always_comb begin
      w_pending_next = r_pending;
      if (!enable || w_start) begin
         w_pending_next = 1'b0;
      end else if (w_btn_rise && (r_state == ST_IDLE)) begin
         w_pending_next = 1'b1;
      end
   end

   always_comb begin
      w_state_next  = r_state;
      w_phase_next  = r_phase_cnt;
      w_height_next = r_height;
      w_land_next   = 1'b0;
      if (w_tick) begin
         w_phase_next = r_phase_cnt + PH_W'(1);
         case (r_state)
            ST_IDLE: begin
               w_phase_next = '0;
               if (w_start) begin
                  w_state_next = ST_RISE;
               end
            end
            ST_RISE: begin
               w_height_next = w_sum[HEIGHT_W] ? '1 : w_sum[HEIGHT_W-1:0];
               if (r_phase_cnt >= RISE_LAST) begin
                  w_state_next = AFTER_RISE;
                  w_phase_next = '0;
               end
            end
            ST_HANG: begin
               if (r_phase_cnt >= HANG_LAST) begin
                  w_state_next = ST_FALL;
                  w_phase_next = '0;
               end
            end
            ST_FALL: begin
               w_height_next = w_diff[HEIGHT_W] ? '0 : w_diff[HEIGHT_W-1:0];
               if (w_height_next == '0) begin
                  w_state_next = ST_COOLDOWN;
                  w_phase_next = '0;
                  w_land_next  = 1'b1;
               end
            end
            ST_COOLDOWN: begin
               if (r_phase_cnt >= COOL_LAST) begin
                  w_state_next = ST_IDLE;
                  w_phase_next = '0;
               end
            end
            default: begin
               w_state_next = ST_IDLE;
               w_phase_next = '0;
            end
         endcase
      end
   end

   always_ff @(posedge proc_clk or negedge reset) begin
      if (!reset) begin
         r_state      <= ST_IDLE;
         r_phase_cnt  <= '0;
         r_height     <= '0;
         r_pending    <= 1'b0;
         r_land_pulse <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_phase_cnt  <= w_phase_next;
         r_height     <= w_height_next;
         r_pending    <= w_pending_next;
         r_land_pulse <= w_land_next;
      end
   end

   assign tick        = w_tick;
   assign jump_active = (r_state == ST_RISE) || (r_state == ST_HANG) || (r_state == ST_FALL);
   assign height      = r_height;
   assign can_jump    = (r_state == ST_IDLE) && enable;
   assign land_pulse  = r_land_pulse;

endmodule
